store_buffer: RTL

- Sits directly downstream of the commit stage's data FIFO port.
- Accepts committed stores (address, value, size) into an in-order FIFO and drains them to the data memory write port over a req/ack handshake.
- Generates byte strobes and lane-replicated write data from size and address.
- Reports a same-word hazard so the load path can stall on a pending store, and reports empty for fence handling.

---
 rtl/store_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// In-order store buffer between the commit data FIFO and the data memory write port.
// Buffers committed stores, drains them over a req/ack handshake, and flags same-word load hazards.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] datafifo_addr_in,
  input  logic [31:0] datafifo_val_in,
  input  logic [1:0]  datafifo_size_in,
  input  logic        datafifo_valid_in,
  output logic        datafifo_full,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  output logic        mem_wr_req,
  input  logic        mem_wr_ack,
  input  logic [31:0] load_check_addr,
  output logic        load_hazard,
  output logic        buffer_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      val_mem  [DEPTH];
  logic [1:0]       size_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic [PTR_W-1:0] rel;
  logic             unused_bits;

  function automatic logic [3:0] strb_gen(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] data_gen(input logic [1:0] size, input logic [31:0] val);
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{val[7:0]}};
      2'd1:    d = {2{val[15:0]}};
      default: d = val;
    endcase
    return d;
  endfunction

  assign datafifo_full = (count == (PTR_W + 1)'(DEPTH));
  assign push          = datafifo_valid_in && !datafifo_full;
  assign pop           = (state == REQ) && mem_wr_ack;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Drain FSM: stays in REQ across back-to-back entries, re-checking occupancy after each ack
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (count != '0) state_nxt = REQ;
      REQ:  if (pop) state_nxt = (count_nxt != '0) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // Entry storage carries no reset; occupancy is tracked solely by head/count
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= datafifo_addr_in;
      val_mem[tail]  <= datafifo_val_in;
      size_mem[tail] <= datafifo_size_in;
    end
  end

  assign head_valid   = (count != '0);
  assign mem_wr_req   = (state == REQ);
  assign buffer_empty = !head_valid && (state == IDLE);
  assign mem_wr_addr  = head_valid ? {addr_mem[head][31:2], 2'b00} : 32'd0;
  assign mem_wr_strb  = head_valid ? strb_gen(size_mem[head], addr_mem[head][1:0]) : 4'd0;
  assign mem_wr_data  = head_valid ? data_gen(size_mem[head], val_mem[head]) : 32'd0;

  // An entry is occupied when its distance from head is below count
  always_comb begin
    load_hazard = 1'b0;
    rel         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head;
      if (({1'b0, rel} < count) && (addr_mem[i][31:2] == load_check_addr[31:2])) begin
        load_hazard = 1'b1;
      end
    end
  end

  assign unused_bits = ^load_check_addr[1:0];

endmodule
